cordic_scheduler: RTL and testbench

Two-requester front end that shares a single fixed-latency CORDIC pipeline between independent clients. It arbitrates requests round-robin and drives the pipeline's input port from a register. A tag delay line tracks which requester owns each in-flight operation. Results are steered into per-requester response FIFOs. Issue is credit-gated: the pipeline cannot stall, so a result is never produced without guaranteed FIFO space.

---
 rtl/cordic_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_cordic_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_scheduler.sv
// Two-requester front end sharing one fixed-latency CORDIC pipeline.
// Round-robin, credit-gated issue; results are steered by a tag line into per-requester FWFT FIFOs.

module cordic_resp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_wr,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic         o_valid,
  output logic         o_full,
  output logic [W-1:0] o_rdata
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wp, r_rp;
  logic         w_we, w_re;

  assign o_valid = (r_wp != r_rp);
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_we    = i_wr && !o_full;
  assign w_re    = i_pop && o_valid;
  // Empty FIFO presents zeros rather than stale storage.
  assign o_rdata = o_valid ? r_mem[r_rp[AW-1:0]] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_we) r_wp <= r_wp + 1'b1;
      if (w_re) r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wp[AW-1:0]] <= i_wdata;
  end
endmodule

module cordic_scheduler #(
  parameter int DATA_WIDTH   = 16,
  parameter int FLIP_WIDTH   = 2,
  parameter int PIPE_LATENCY = 6,
  parameter int RESP_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [2*DATA_WIDTH-1:0] req_degree,
  input  logic [2*DATA_WIDTH-1:0] req_x,
  input  logic [2*DATA_WIDTH-1:0] req_y,
  input  logic [2*FLIP_WIDTH-1:0] req_flip,
  input  logic [1:0]              req_arctan,
  output logic [1:0]              resp_valid,
  input  logic [1:0]              resp_ready,
  output logic [2*DATA_WIDTH-1:0] resp_degree,
  output logic [2*DATA_WIDTH-1:0] resp_x,
  output logic [2*DATA_WIDTH-1:0] resp_y,
  output logic [2*FLIP_WIDTH-1:0] resp_flip,
  output logic [1:0]              resp_arctan,
  output logic [DATA_WIDTH-1:0]   pipe_degree,
  output logic [DATA_WIDTH-1:0]   pipe_x,
  output logic [DATA_WIDTH-1:0]   pipe_y,
  output logic [FLIP_WIDTH-1:0]   pipe_flip,
  output logic                    pipe_arctan_en,
  output logic                    pipe_valid,
  input  logic [DATA_WIDTH-1:0]   pipe_degree_out,
  input  logic [DATA_WIDTH-1:0]   pipe_x_out,
  input  logic [DATA_WIDTH-1:0]   pipe_y_out,
  input  logic [FLIP_WIDTH-1:0]   pipe_flip_out,
  input  logic                    pipe_arctan_en_out,
  input  logic                    pipe_valid_out,
  output logic                    busy,
  output logic                    err
);
  localparam int DW = DATA_WIDTH;
  localparam int FW = FLIP_WIDTH;
  localparam int L  = PIPE_LATENCY;
  localparam int CW = $clog2(RESP_DEPTH) + 1;
  localparam int RW = 3*DW + FW + 1;

  logic [1:0][CW-1:0] r_credit;
  logic               r_prio;
  logic               r_id;
  logic               r_err;
  logic [L-1:0]       r_tag_v, r_tag_id;
  logic [1:0]         w_elig, w_pop, w_wr, w_full;
  logic               w_gnt_any, w_gnt_id, w_tag_vo, w_tag_id;
  logic [L:0]         w_tag_v_nxt, w_tag_id_nxt;
  logic [RW-1:0]      w_wdata;
  logic [1:0][RW-1:0] w_rdata;

  // Arbitration: a tie goes to r_prio, a lone eligible requester wins outright.
  always_comb begin
    for (int k = 0; k < 2; k++) w_elig[k] = req_valid[k] && (r_credit[k] != '0);
    w_gnt_any = |w_elig;
    w_gnt_id  = (&w_elig) ? r_prio : w_elig[1];
    req_ready = w_gnt_any ? (2'b01 << w_gnt_id) : 2'b00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prio         <= 1'b0;
      r_id           <= 1'b0;
      pipe_valid     <= 1'b0;
      pipe_degree    <= '0;
      pipe_x         <= '0;
      pipe_y         <= '0;
      pipe_flip      <= '0;
      pipe_arctan_en <= 1'b0;
    end else begin
      pipe_valid <= w_gnt_any;
      if (w_gnt_any) begin
        r_prio         <= ~w_gnt_id;
        r_id           <= w_gnt_id;
        pipe_degree    <= req_degree[int'(w_gnt_id)*DW +: DW];
        pipe_x         <= req_x[int'(w_gnt_id)*DW +: DW];
        pipe_y         <= req_y[int'(w_gnt_id)*DW +: DW];
        pipe_flip      <= req_flip[int'(w_gnt_id)*FW +: FW];
        pipe_arctan_en <= req_arctan[w_gnt_id];
      end
    end
  end

  // Tag line mirrors the pipeline depth so its output lines up with pipe_valid_out.
  assign w_tag_v_nxt  = {r_tag_v, pipe_valid};
  assign w_tag_id_nxt = {r_tag_id, r_id};
  assign w_tag_vo     = r_tag_v[L-1];
  assign w_tag_id     = r_tag_id[L-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tag_v  <= '0;
      r_tag_id <= '0;
    end else begin
      r_tag_v  <= w_tag_v_nxt[L-1:0];
      r_tag_id <= w_tag_id_nxt[L-1:0];
    end
  end

  assign w_wdata = {pipe_degree_out, pipe_x_out, pipe_y_out, pipe_flip_out, pipe_arctan_en_out};
  assign w_pop   = resp_valid & resp_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) r_credit[k] <= CW'(RESP_DEPTH);
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (req_ready[k] && !w_pop[k])      r_credit[k] <= r_credit[k] - 1'b1;
        else if (!req_ready[k] && w_pop[k]) r_credit[k] <= r_credit[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_err <= 1'b0;
    else        r_err <= r_err | (pipe_valid_out != w_tag_vo) | (|(w_wr & w_full));
  end
  assign err = r_err;

  for (genvar k = 0; k < 2; k++) begin : g_resp
    assign w_wr[k] = w_tag_vo && (w_tag_id == 1'(k));
    cordic_resp_fifo #(.W(RW), .DEPTH(RESP_DEPTH)) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .i_wr   (w_wr[k]),
      .i_wdata(w_wdata),
      .i_pop  (resp_ready[k]),
      .o_valid(resp_valid[k]),
      .o_full (w_full[k]),
      .o_rdata(w_rdata[k])
    );
    assign {resp_degree[k*DW +: DW], resp_x[k*DW +: DW], resp_y[k*DW +: DW],
            resp_flip[k*FW +: FW], resp_arctan[k]} = w_rdata[k];
  end

  assign busy = (|r_tag_v) | pipe_valid | (|resp_valid);
endmodule

// File: tb/tb_cordic_scheduler.sv
// Randomized and directed bench for cordic_scheduler with a fixed-latency pipeline stand-in
// and a queue-based reference of accepted-but-unpopped operations per requester.

module tb_cordic_scheduler;
  localparam int DW = 16;
  localparam int FW = 2;
  localparam int PL = 6;
  localparam int D  = 4;
  localparam int RW = 3*DW + FW + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] req_valid = '0, resp_ready = '0, req_arctan = '0;
  logic [2*DW-1:0] req_degree = '0, req_x = '0, req_y = '0;
  logic [2*FW-1:0] req_flip = '0;
  logic [1:0] req_ready, resp_valid, resp_arctan;
  logic [2*DW-1:0] resp_degree, resp_x, resp_y;
  logic [2*FW-1:0] resp_flip;
  logic [DW-1:0] pipe_degree, pipe_x, pipe_y, pipe_degree_out, pipe_x_out, pipe_y_out;
  logic [FW-1:0] pipe_flip, pipe_flip_out;
  logic pipe_arctan_en, pipe_valid, pipe_arctan_en_out, pipe_valid_out, busy, err;
  logic frc = 1'b0;

  always #5 clk = ~clk;

  cordic_scheduler #(.DATA_WIDTH(DW), .FLIP_WIDTH(FW), .PIPE_LATENCY(PL), .RESP_DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_degree(req_degree), .req_x(req_x), .req_y(req_y),
    .req_flip(req_flip), .req_arctan(req_arctan),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_degree(resp_degree), .resp_x(resp_x), .resp_y(resp_y),
    .resp_flip(resp_flip), .resp_arctan(resp_arctan),
    .pipe_degree(pipe_degree), .pipe_x(pipe_x), .pipe_y(pipe_y),
    .pipe_flip(pipe_flip), .pipe_arctan_en(pipe_arctan_en), .pipe_valid(pipe_valid),
    .pipe_degree_out(pipe_degree_out), .pipe_x_out(pipe_x_out), .pipe_y_out(pipe_y_out),
    .pipe_flip_out(pipe_flip_out), .pipe_arctan_en_out(pipe_arctan_en_out),
    .pipe_valid_out(pipe_valid_out),
    .busy(busy), .err(err)
  );

  // Stand-in pipeline: a distinct transform per field so misrouted data is visible.
  function automatic logic [RW-1:0] xf(input logic [RW-1:0] w);
    logic [DW-1:0] d, x, y;
    logic [FW-1:0] f;
    logic a;
    {d, x, y, f, a} = w;
    return {d + 16'h0123, ~x, y ^ 16'h5A5A, f, a};
  endfunction

  logic [PL-1:0] p_v;
  logic [RW-1:0] p_w [PL];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_v <= '0;
      for (int i = 0; i < PL; i++) p_w[i] <= '0;
    end else begin
      p_v    <= {p_v[PL-2:0], pipe_valid};
      p_w[0] <= xf({pipe_degree, pipe_x, pipe_y, pipe_flip, pipe_arctan_en});
      for (int i = 1; i < PL; i++) p_w[i] <= p_w[i-1];
    end
  end
  assign {pipe_degree_out, pipe_x_out, pipe_y_out, pipe_flip_out, pipe_arctan_en_out} = p_w[PL-1];
  assign pipe_valid_out = p_v[PL-1] | frc;

  typedef struct { logic [RW-1:0] w; int rdy; } ent_t;
  ent_t q0[$], q1[$];
  int m_out[2], acc[2];
  int m_pref, cyc;
  logic m_pv, m_err;
  logic [RW-1:0] m_pw;
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [RW-1:0] reqw(input int k);
    return {req_degree[k*DW +: DW], req_x[k*DW +: DW], req_y[k*DW +: DW], req_flip[k*FW +: FW], req_arctan[k]};
  endfunction

  function automatic logic [RW-1:0] respw(input int k);
    return {resp_degree[k*DW +: DW], resp_x[k*DW +: DW], resp_y[k*DW +: DW], resp_flip[k*FW +: FW], resp_arctan[k]};
  endfunction

  task automatic randpay();
    req_degree = 32'($urandom); req_x = 32'($urandom); req_y = 32'($urandom);
    req_flip = 4'($urandom); req_arctan = 2'($urandom);
  endtask

  // One cycle: check outputs against the reference, then advance the reference.
  task automatic step();
    logic [1:0] eg, er, ev;
    int gid;
    ent_t e;
    #1;
    for (int k = 0; k < 2; k++) eg[k] = req_valid[k] && (m_out[k] < D);
    gid = -1;
    if (eg == 2'b11) gid = m_pref;
    else if (eg[0]) gid = 0;
    else if (eg[1]) gid = 1;
    er = '0;
    if (gid >= 0) er[gid] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("pipe_valid", pipe_valid, m_pv);
    if (m_pv) chk("pipe_word", {pipe_degree, pipe_x, pipe_y, pipe_flip, pipe_arctan_en}, m_pw);
    ev[0] = (q0.size() > 0) && (q0[0].rdy <= cyc);
    ev[1] = (q1.size() > 0) && (q1[0].rdy <= cyc);
    chk("resp_valid", resp_valid, ev);
    if (ev[0]) chk("resp0_word", respw(0), q0[0].w);
    if (ev[1]) chk("resp1_word", respw(1), q1[0].w);
    chk("busy", busy, (q0.size() + q1.size()) != 0);
    chk("err", err, m_err);
    m_pv = (gid >= 0);
    if (gid >= 0) begin
      m_pw  = reqw(gid);
      e.w   = xf(m_pw);
      e.rdy = cyc + PL + 2;
      if (gid == 0) q0.push_back(e); else q1.push_back(e);
      m_out[gid]++;
      acc[gid]++;
      m_pref = 1 - gid;
    end
    if (ev[0] && resp_ready[0]) begin void'(q0.pop_front()); m_out[0]--; end
    if (ev[1] && resp_ready[1]) begin void'(q1.pop_front()); m_out[1]--; end
    if (frc) m_err = 1'b1;
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input logic [1:0] v, input logic [1:0] r, input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = v; resp_ready = r; randpay();
      step();
    end
  endtask

  task automatic do_reset();
    req_valid = '0; resp_ready = '0; frc = 1'b0;
    reset = 1'b0;
    q0.delete(); q1.delete();
    m_out = '{0, 0}; m_pref = 0; m_pv = 1'b0; m_err = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_pipe_valid", pipe_valid, 1'b0);
    chk("rst_pipe_word", {pipe_degree, pipe_x, pipe_y, pipe_flip, pipe_arctan_en}, '0);
    chk("rst_resp_valid", resp_valid, 2'b00);
    chk("rst_resp0", respw(0), '0);
    chk("rst_resp1", respw(1), '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    cyc = 0;
    acc = '{0, 0};
    do_reset();

    // Single rotation from requester 0.
    req_valid = 2'b01; resp_ready = 2'b00;
    req_degree = 32'h0000_1E00; req_x = 32'h0000_0100; req_y = '0; req_flip = '0; req_arctan = '0;
    step();
    req_valid = 2'b00;
    for (int i = 1; i <= 9; i++) begin
      #1;
      if (i == 1) chk("single_pv1", pipe_valid, 1'b1);
      if (i == 7) chk("single_rv7", resp_valid, 2'b00);
      if (i == 8) chk("single_rv8", resp_valid, 2'b01);
      if (i == 8) chk("single_word", respw(0), xf({16'h1E00, 16'h0100, 16'h0000, 2'b00, 1'b0}));
      step();
    end
    run(2'b00, 2'b11, 3);

    // Alternation from reset with both requesters contending.
    do_reset();
    req_valid = 2'b11; resp_ready = 2'b11;
    for (int i = 0; i < 20; i++) begin
      randpay();
      #1;
      if (i < 8) chk("alternate", req_ready, (i % 2) ? 2'b10 : 2'b01);
      step();
    end
    run(2'b00, 2'b11, 12);

    // Credit exhaustion on requester 0, then a single pop returns exactly one credit.
    acc = '{0, 0};
    run(2'b11, 2'b10, 20);
    chk("exhaust_acc0", acc[0], 4);
    acc = '{0, 0};
    run(2'b11, 2'b11, 1);
    run(2'b11, 2'b10, 12);
    chk("one_pop_acc0", acc[0], 1);

    // Accept and pop together while holding one credit.
    acc = '{0, 0};
    run(2'b00, 2'b01, 1);
    run(2'b01, 2'b01, 1);
    run(2'b01, 2'b00, 5);
    chk("same_cycle_acc0", acc[0], 2);
    chk("same_cycle_err", err, 1'b0);
    run(2'b00, 2'b11, 16);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      req_valid = 2'($urandom);
      resp_ready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      randpay();
      step();
    end
    run(2'b00, 2'b11, 16);

    // Reset three cycles after an accept.
    run(2'b01, 2'b11, 1);
    run(2'b00, 2'b11, 3);
    do_reset();
    run(2'b00, 2'b11, 12);
    acc = '{0, 0};
    run(2'b01, 2'b00, 12);
    chk("post_reset_acc0", acc[0], 4);
    run(2'b00, 2'b00, 6);

    // Spurious pipeline valid with nothing issued.
    frc = 1'b1;
    step();
    frc = 1'b0;
    run(2'b00, 2'b00, 5);
    chk("err_sticky", err, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
